// File: rtl/truth_table_checker.sv
// truth_table_checker: steps a small combinational DUT through every input
// pattern, samples its output at the end of each hold and scores it against EXPECTED.
`default_nettype none

module truth_table_checker #(
    parameter int                            N_INPUTS    = 2,
    parameter int                            HOLD_CYCLES = 250,
    parameter logic [(1 << N_INPUTS) - 1:0]  EXPECTED    = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [N_INPUTS-1:0]   dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_INPUTS:0]     err_count,
    output logic                  first_err_valid,
    output logic [N_INPUTS-1:0]   first_err_idx
);

    localparam logic [15:0]         HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] LAST_PAT  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [N_INPUTS-1:0] dut_in_q;
    logic [15:0]         hold_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [N_INPUTS:0]   err_q;
    logic                fev_q;
    logic [N_INPUTS-1:0] fei_q;

    logic                mismatch;
    logic [N_INPUTS:0]   err_d;

    // err_d already includes a mismatch on the pattern being sampled, so the
    // final pass flag accounts for the last pattern on the same edge.
    assign mismatch = (dut_out != EXPECTED[dut_in_q]);
    assign err_d    = err_q + {{N_INPUTS{1'b0}}, mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fei_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        dut_in_q <= '0;
                        hold_q   <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        err_q    <= '0;
                        fev_q    <= 1'b0;
                        fei_q    <= '0;
                    end
                end
                S_RUN: begin
                    if (hold_q == HOLD_LAST) begin
                        err_q <= err_d;
                        if (mismatch && !fev_q) begin
                            fev_q <= 1'b1;
                            fei_q <= dut_in_q;
                        end
                        if (dut_in_q == LAST_PAT) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            dut_in_q <= dut_in_q + 1'b1;
                            hold_q   <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three instances (N=2/H=4 AND, N=3/H=1 XOR3,
// N=1/H=2 NOT) scored against a time-based model of the run.
`default_nettype none

module tb_truth_table_checker;

    localparam int M_AND = 0, M_OR = 1, M_XOR3 = 2, M_ZERO = 3, M_NOT = 4, M_ONE = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start   [3];
    int         mode    [3];
    logic [7:0] din     [3];
    logic       dout    [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       pass_a  [3];
    logic [8:0] errc    [3];
    logic       fev     [3];
    logic [7:0] fei     [3];

    int checks   = 0;
    int failures = 0;

    // Model state: run active, cycles elapsed since the start edge, captured DUT kind
    logic m_act  [3];
    int   m_t    [3];
    int   m_mode [3];

    function automatic int n_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 3 : 1;
    endfunction
    function automatic int hold_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 2;
    endfunction
    function automatic logic [7:0] tab_of(input int i);
        return (i == 0) ? 8'h08 : (i == 1) ? 8'h96 : 8'h01;
    endfunction

    function automatic logic resp(input int m, input logic [7:0] p);
        case (m)
            M_AND:   return p[1] & p[0];
            M_OR:    return p[1] | p[0];
            M_XOR3:  return ^p[2:0];
            M_ZERO:  return 1'b0;
            M_NOT:   return ~p[0];
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) dout[i] = resp(mode[i], din[i]);
    end

    logic [1:0] d0_in; logic [2:0] e0; logic [1:0] f0;
    logic [2:0] d1_in; logic [3:0] e1; logic [2:0] f1;
    logic [0:0] d2_in; logic [1:0] e2; logic [0:0] f2;

    truth_table_checker #(.N_INPUTS(2), .HOLD_CYCLES(4), .EXPECTED(4'b1000)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_in(d0_in), .dut_out(dout[0]),
        .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .err_count(e0),
        .first_err_valid(fev[0]), .first_err_idx(f0));
    truth_table_checker #(.N_INPUTS(3), .HOLD_CYCLES(1), .EXPECTED(8'b1001_0110)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_in(d1_in), .dut_out(dout[1]),
        .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .err_count(e1),
        .first_err_valid(fev[1]), .first_err_idx(f1));
    truth_table_checker #(.N_INPUTS(1), .HOLD_CYCLES(2), .EXPECTED(2'b01)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_in(d2_in), .dut_out(dout[2]),
        .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .err_count(e2),
        .first_err_valid(fev[2]), .first_err_idx(f2));

    assign din[0]  = {6'd0, d0_in};
    assign din[1]  = {5'd0, d1_in};
    assign din[2]  = {7'd0, d2_in};
    assign errc[0] = {6'd0, e0};
    assign errc[1] = {5'd0, e1};
    assign errc[2] = {7'd0, e2};
    assign fei[0]  = {6'd0, f0};
    assign fei[1]  = {5'd0, f1};
    assign fei[2]  = {7'd0, f2};

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[u%0d] got=%0d want=%0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_mode[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_act[i] || m_t[i] >= (hold_of(i) << n_of(i))) begin
                    if (start[i]) begin
                        m_act[i]  <= 1'b1;
                        m_t[i]    <= 0;
                        m_mode[i] <= mode[i];
                    end
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    // After t edges a pattern p is scored once (p+1)*HOLD <= t.
    task automatic model_expect(input int i, output logic [31:0] e_din, output logic [31:0] e_busy,
                                output logic [31:0] e_done, output logic [31:0] e_pass,
                                output logic [31:0] e_err, output logic [31:0] e_fev,
                                output logic [31:0] e_fei);
        int npat, tot, comp;
        logic [7:0] tab;
        npat = 1 << n_of(i);
        tot  = npat * hold_of(i);
        tab  = tab_of(i);
        comp = 0;
        e_din = 0; e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fev = 0; e_fei = 0;
        if (m_act[i]) begin
            if (m_t[i] < tot) begin
                e_busy = 1;
                e_din  = m_t[i] / hold_of(i);
                comp   = m_t[i] / hold_of(i);
            end else begin
                e_done = 1;
                e_din  = npat - 1;
                comp   = npat;
            end
            for (int p = 0; p < comp; p++) begin
                if (resp(m_mode[i], 8'(p)) != tab[p]) begin
                    if (e_fev == 0) begin
                        e_fev = 1;
                        e_fei = p;
                    end
                    e_err++;
                end
            end
            if (e_done == 1) e_pass = (e_err == 0) ? 1 : 0;
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] a, b, c, d, e, f, g;
        for (int i = 0; i < 3; i++) begin
            model_expect(i, a, b, c, d, e, f, g);
            chk("dut_in", i, 32'(din[i]), a);
            chk("busy", i, 32'(busy_a[i]), b);
            chk("done", i, 32'(done_a[i]), c);
            chk("pass", i, 32'(pass_a[i]), d);
            chk("err_count", i, 32'(errc[i]), e);
            chk("first_err_valid", i, 32'(fev[i]), f);
            chk("first_err_idx", i, 32'(fei[i]), g);
        end
    end

    // Caller sits just after an edge; starts are forced at relative edges ign_a+1 / ign_b+1.
    task automatic run(input int i, input int ign_a, input int ign_b, output int cnt);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        cnt = 0;
        while (!done_a[i] && cnt < 2000) begin
            start[i] = (cnt == ign_a || cnt == ign_b);
            @(posedge clk); #1;
            cnt++;
        end
        start[i] = 1'b0;
    endtask

    task automatic lit(input int i, input int cnt, input int lat, input int err,
                       input int fv, input int fi, input int ps);
        chk("lit_latency", i, 32'(cnt), 32'(lat));
        chk("lit_err_count", i, 32'(errc[i]), 32'(err));
        chk("lit_first_err_valid", i, 32'(fev[i]), 32'(fv));
        chk("lit_first_err_idx", i, 32'(fei[i]), 32'(fi));
        chk("lit_pass", i, 32'(pass_a[i]), 32'(ps));
        chk("lit_busy", i, 32'(busy_a[i]), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            mode[i]  = M_AND;
        end
        mode[1] = M_XOR3;
        mode[2] = M_NOT;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 0, 32'(done_a[0]), 32'd0);
        chk("reset_din", 0, 32'(din[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Correct AND DUT
        mode[0] = M_AND;
        run(0, -1, -1, cnt);
        lit(0, cnt, 16, 0, 0, 0, 1);
        chk("lit_din_last", 0, 32'(din[0]), 32'd3);

        // OR DUT: patterns 1 and 2 mismatch
        mode[0] = M_OR;
        run(0, -1, -1, cnt);
        lit(0, cnt, 16, 2, 1, 1, 0);

        // Starts at relative edges 5 and 9 are ignored; then restart from DONE
        run(0, 4, 8, cnt);
        lit(0, cnt, 16, 2, 1, 1, 0);
        run(0, -1, -1, cnt);
        lit(0, cnt, 16, 2, 1, 1, 0);

        // Reset mid-run
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", 0, 32'(busy_a[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("rst_err", 0, 32'(errc[0]), 32'd0);
        chk("rst_din", 0, 32'(din[0]), 32'd0);
        chk("rst_fev", 0, 32'(fev[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, -1, -1, cnt);
        lit(0, cnt, 16, 2, 1, 1, 0);

        // XOR3, HOLD=1
        run(1, -1, -1, cnt);
        lit(1, cnt, 8, 0, 0, 0, 1);
        mode[1] = M_ZERO;
        run(1, -1, -1, cnt);
        lit(1, cnt, 8, 4, 1, 1, 0);

        // NOT, N=1
        run(2, -1, -1, cnt);
        lit(2, cnt, 4, 0, 0, 0, 1);
        mode[2] = M_ONE;
        run(2, -1, -1, cnt);
        lit(2, cnt, 4, 1, 1, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking exhaustive truth-table engine: the response side of the gate-level stimulus benches. It drives every input combination of a small combinational DUT (up to 8 inputs), holds each pattern for a programmable number of cycles, and samples the DUT output at the end of each hold. It compares each sample against a parameterised expected truth table, counts mismatches and reports pass/fail. On the lab board it sits between the push-button/switch front end and the DUT (andgate, orgate, part2..part5 style blocks), so a lab exercise can be verified in hardware without a simulator.

## Interface
- N_INPUTS, 2: number of DUT inputs, legal range 1..8
- HOLD_CYCLES, 250: clock cycles each pattern is held, legal range 1..65535
- EXPECTED, 4'b1000: 2^N_INPUTS-bit truth table; bit i is the expected DUT output for pattern i (pattern bit N_INPUTS-1 maps to input1, LSB to the last input)

Ports:
- clk  input  1  single system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle (or level) request to begin a run; sampled only in IDLE or DONE
- dut_in  output  N_INPUTS  pattern driven to the DUT inputs
- dut_out  input  1  DUT response, same clock domain, combinational from dut_in
- busy  output  1  high while a run is in progress
- done  output  1  high from run completion until the next start or reset
- pass  output  1  valid while done=1; high iff err_count==0
- err_count  output  N_INPUTS+1  number of mismatching patterns in the current or last run
- first_err_valid  output  1  high once any mismatch has been recorded in this run
- first_err_idx  output  N_INPUTS  index of the first mismatching pattern

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, hold counter=0.
- IDLE: start=1 -> RUN. On the same edge: dut_in=0, hold counter=0, err_count=0, first_err_valid=0, first_err_idx=0, busy=1.
- RUN: the hold counter increments each cycle. When the counter is HOLD_CYCLES-1, dut_out is compared with EXPECTED[dut_in] in that cycle:
  - Mismatch: err_count increments. If first_err_valid=0, first_err_idx=dut_in and first_err_valid=1.
  - If dut_in is not 2^N_INPUTS-1: dut_in increments and the counter returns to 0.
  - Otherwise: go to DONE with busy=0 and done=1. pass=(final err_count==0), including any mismatch on the last pattern.
- DONE: dut_in holds its last pattern. All results are stable. start=1 behaves exactly like start in IDLE, clearing the results and starting a new run; done drops on that edge.
- start during RUN is ignored and does not restart the run.
- rst_n low at any time, including mid-run, immediately forces all reset values; there is no partial result retention.
- Widths: err_count saturates by construction, since the maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits. The hold counter is 16 bits. dut_in wraps only by leaving RUN and never overflows.
- HOLD_CYCLES=1: each pattern is held one cycle and is sampled in that same cycle.

## Timing
- A start sampled at edge k produces dut_in=0 and busy=1 after edge k.
- Pattern p is driven from edge k+p·HOLD_CYCLES to edge k+(p+1)·HOLD_CYCLES. It is sampled in the cycle just before the latter edge.
- done=1 and busy=0 appear after edge k+2^N_INPUTS·HOLD_CYCLES. err_count, first_err_* and pass are final on that same edge.
- DUT settling budget is HOLD_CYCLES-1 cycles plus one cycle of combinational path. The DUT must settle within one clock period for HOLD_CYCLES=1.
- busy and done are never high simultaneously. Both are low only in IDLE.

## Test plan
- N=2, HOLD=4, EXPECTED=4'b1000, with a correct AND model; start pulse at edge 0 -> dut_in steps 0,1,2,3 every 4 cycles; done=1 after edge 16; pass=1, err_count=0, first_err_valid=0.
- Same parameters with an OR model as the DUT -> mismatches at patterns 1 and 2; err_count=2, first_err_idx=1, first_err_valid=1, pass=0.
- N=3, HOLD=1, EXPECTED=8'b1001_0110 (XOR3), with an XOR3 model -> done after 8 cycles, pass=1. Repeat with the output stuck at 0 -> err_count=4, first_err_idx=1.
- Pulse start again at edges 5 and 9 of a run -> both ignored, and done still occurs at edge 16. Then start in DONE -> results cleared, done low for the next run, same results repeated.
- Assert rst_n low at edge 7 of a run with an OR model -> all outputs return to reset values asynchronously. A fresh start gives a full run with err_count=2, not carried over.
- N=1, HOLD=2, EXPECTED=2'b01 (NOT), with a NOT model -> done after 4 cycles, pass=1. Force dut_out=1 -> err_count=1, first_err_idx=1.
